// File: rtl/div_q8_24_pkg.sv
// Purpose: shared constants, FSM state type and magnitude helper for the Q8.24 divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_q824_pkg;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 24;
  localparam int ITER      = WIDTH + FRAC_BITS;  // one quotient bit per dividend bit
  localparam int CNT_W     = 6;

  localparam logic [WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [WIDTH-1:0] Q_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Two's-complement magnitude as an unsigned value; -2^31 maps to 2^31 exactly.
  function automatic logic [WIDTH-1:0] mag32(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_q8_24_udiv_iter.sv
// Purpose: unsigned restoring-division step datapath (remainder/quotient shift registers).
// Latency: one quotient bit per step; ITER steps after load for a full quotient.
// Backpressure: none; the controller decides when to load and step.
// Ports: load captures dividend/divisor, step performs one iteration, quo is the quotient register.
module udiv_iter
  import div_q824_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [ITER-1:0]  dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [ITER-1:0]  quo
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [ITER-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  // Shifted partial remainder needs 33 bits; after a successful subtract it
  // is always below the divisor, so 32 bits suffice for storage.
  logic [WIDTH:0]   rem_sh;
  logic             ge;

  // The quotient register doubles as the dividend shift register: dividend
  // bits leave at the MSB while quotient bits enter at the LSB.
  always_comb begin
    rem_sh = {rem_q, quo_q[ITER-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      if (ge) begin
        rem_d = rem_sh[WIDTH-1:0] - dvs_q;
        quo_d = {quo_q[ITER-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        quo_d = {quo_q[ITER-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quo = quo_q;

endmodule

// File: rtl/div_q8_24.sv
// Purpose: signed Q8.24 divider q = trunc(a*2^24/b) with saturation and divide-by-zero flag.
// Latency: 57 cycles from accepted start to valid; next start accepted in the valid cycle.
// Backpressure: single-issue; start while busy is dropped, not queued.
// Ports: start/a/b request, q/div_by_zero registered result, valid one-cycle pulse, busy in flight.
module div_q8_24
  import div_q824_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;      // result sign
  logic             a_neg_q, a_neg_d;  // numerator sign, picks the b==0 rail
  logic             bz_q, bz_d;        // sampled b was zero
  logic [WIDTH-1:0] res_q, res_d;
  logic             valid_q, valid_d;
  logic             dbz_q, dbz_d;

  logic             load;
  logic             step;
  logic [ITER-1:0]  quo;
  logic [WIDTH-1:0] res_sat;
  logic             ovf;

  assign load = (state_q == IDLE) && start;
  assign step = (state_q == RUN);

  udiv_iter u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .dividend ({mag32(a), {FRAC_BITS{1'b0}}}),
    .divisor  (mag32(b)),
    .quo      (quo)
  );

  // Any magnitude bit at or above 2^31 overflows a positive result; for a
  // negative result magnitude 2^31 is exactly Q_MIN, so both cases clamp the same way.
  assign ovf = |quo[ITER-1:WIDTH-1];

  always_comb begin
    res_sat = quo[WIDTH-1:0];
    if (bz_q) begin
      res_sat = a_neg_q ? Q_MIN : Q_MAX;
    end else if (!neg_q) begin
      res_sat = ovf ? Q_MAX : quo[WIDTH-1:0];
    end else begin
      res_sat = ovf ? Q_MIN : (~quo[WIDTH-1:0] + 1'b1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    a_neg_d = a_neg_q;
    bz_d    = bz_q;
    res_d   = res_q;
    valid_d = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_W'(ITER - 1);
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
          a_neg_d = a[WIDTH-1];
          bz_d    = (b == '0);
        end
      end
      RUN: begin
        if (cnt_q == '0) state_d = FINISH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FINISH: begin
        res_d   = res_sat;
        dbz_d   = bz_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      bz_q    <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      a_neg_q <= a_neg_d;
      bz_q    <= bz_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q           = res_q;
  assign valid       = valid_q;
  assign busy        = (state_q != IDLE);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_q8_24.sv
// Purpose: directed vector bench for div_q8_24 plus handshake, back-to-back and reset sequences.
// Latency: expects valid 57 edges after the accepting edge.
// Backpressure: checks that a start while busy is ignored.
module tb_div_q8_24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] q;
  logic        valid;
  logic        busy;
  logic        dbz;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_q8_24 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .q           (q),
    .valid       (valid),
    .busy        (busy),
    .div_by_zero (dbz)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one start pulse; returns at the falling edge just after the accepting edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the falling edge after the accepting edge (lat 0). Returns in the valid cycle.
  task automatic wait_valid(output int lat, output int bcnt,
                            output logic [31:0] rq, output logic rdbz);
    lat  = 0;
    bcnt = 0;
    while (!valid && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    rq   = q;
    rdbz = dbz;
  endtask

  initial begin
    int          lat;
    int          bcnt;
    int          vcnt;
    logic [31:0] rq;
    logic        rd;

    vecs[0]  = '{32'h0100_0000, 32'h0200_0000, 32'h0080_0000, 1'b0};
    vecs[1]  = '{32'h0380_0000, 32'h0140_0000, 32'h02CC_CCCC, 1'b0};
    vecs[2]  = '{32'hFE00_0000, 32'h0080_0000, 32'hFC00_0000, 1'b0};
    vecs[3]  = '{32'h0080_0000, 32'hFC00_0000, 32'hFFE0_0000, 1'b0};
    vecs[4]  = '{32'hFE80_0000, 32'hFD00_0000, 32'h0080_0000, 1'b0};
    vecs[5]  = '{32'h6400_0000, 32'h0080_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[6]  = '{32'h9C00_0000, 32'h0080_0000, 32'h8000_0000, 1'b0};
    vecs[7]  = '{32'h0100_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[8]  = '{32'hFF00_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    vecs[9]  = '{32'h0000_0000, 32'h0100_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h0100_0000, 32'h8000_0000, 1'b0};  // -128/1 exact
    vecs[11] = '{32'h8000_0000, 32'hFF00_0000, 32'h7FFF_FFFF, 1'b0};  // -128/-1 overflows
    vecs[12] = '{32'h0000_0001, 32'h0200_0000, 32'h0000_0000, 1'b0};  // 0.5 LSB truncates
    vecs[13] = '{32'h0000_0003, 32'hFE00_0000, 32'hFFFF_FFFF, 1'b0};  // -1.5 LSB -> -1
    vecs[14] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0100_0000, 1'b0};
    vecs[15] = '{32'h0000_0000, 32'hFF00_0000, 32'h0000_0000, 1'b0};

    #1;
    chk("reset q", q, 32'h0);
    chk("reset valid", {31'b0, valid}, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset dbz", {31'b0, dbz}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_valid(lat, bcnt, rq, rd);
      chk($sformatf("vec%0d q", i), rq, vecs[i].q);
      chk($sformatf("vec%0d dbz", i), {31'b0, rd}, {31'b0, vecs[i].dbz});
      chki($sformatf("vec%0d latency", i), lat, 57);
      chki($sformatf("vec%0d busy cycles", i), bcnt, 57);
    end

    // Valid is a single-cycle pulse and q holds while inputs move.
    issue(32'h0100_0000, 32'h0200_0000);
    wait_valid(lat, bcnt, rq, rd);
    chk("pulse busy in valid cycle", {31'b0, busy}, 32'h0);
    @(negedge clk);
    chk("pulse valid drops", {31'b0, valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
    chk("hold q", q, 32'h0080_0000);

    // A start while busy is neither queued nor resamples operands.
    issue(32'h0380_0000, 32'h0140_0000);
    repeat (9) @(negedge clk);
    a     = 32'h7FFF_FFFF;
    b     = 32'h0100_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(lat, bcnt, rq, rd);
    chk("ignored start q", rq, 32'h02CC_CCCC);
    chki("ignored start latency", lat + 10, 57);
    vcnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chki("ignored start no second valid", vcnt, 0);

    // Back-to-back: start raised in the valid cycle is accepted immediately.
    issue(32'hFE00_0000, 32'h0080_0000);
    wait_valid(lat, bcnt, rq, rd);
    chk("b2b first q", rq, 32'hFC00_0000);
    a     = 32'h0080_0000;
    b     = 32'hFC00_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b accepted busy", {31'b0, busy}, 32'h1);
    wait_valid(lat, bcnt, rq, rd);
    chk("b2b second q", rq, 32'hFFE0_0000);
    chki("b2b second latency", lat, 57);

    // Reset mid-operation after a divide-by-zero left dbz and q set.
    issue(32'h0100_0000, 32'h0000_0000);
    wait_valid(lat, bcnt, rq, rd);
    chk("pre-reset dbz", {31'b0, rd}, 32'h1);
    issue(32'h0380_0000, 32'h0140_0000);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset q", q, 32'h0);
    chk("midreset valid", {31'b0, valid}, 32'h0);
    chk("midreset busy", {31'b0, busy}, 32'h0);
    chk("midreset dbz", {31'b0, dbz}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid || busy) vcnt++;
    end
    chki("midreset no valid or busy", vcnt, 0);
    issue(32'hFE80_0000, 32'hFD00_0000);
    wait_valid(lat, bcnt, rq, rd);
    chk("post-reset q", rq, 32'h0080_0000);
    chk("post-reset dbz", {31'b0, rd}, 32'h0);
    chki("post-reset latency", lat, 57);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
